// File: rtl/esfa_report_pkg.sv
// Shared types and constants for the ESFA result reporter.
// Frame length follows ESFA_REPORT_CHECKSUM_EN (4 bytes with checksum, 3 without).
package esfa_report_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam logic [7:0] STATUS_PASS         = 8'h01;
   localparam logic [7:0] STATUS_FAIL         = 8'h00;
   localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hE5;

`ifdef ESFA_REPORT_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 4;
`else
   localparam int unsigned FRAME_LEN = 3;
`endif

   localparam int unsigned IDX_W = 2;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first byte serialiser; accepts a new byte in IDLE or on the last
// stop-bit cycle so back-to-back bytes go out with no idle gap.
module uart_tx_byte
   import esfa_report_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready_c,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int unsigned    CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      r_state;
   uart_state_e      w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_bit;
   logic [2:0]       w_bit_nxt;
   logic [7:0]       r_data;
   logic             r_tx;
   logic             w_tx_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             w_tick;

   assign w_tick = (r_cnt == CNT_MAX);

   // State and datapath registers; tx/busy are registered from next-state values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         if (i_valid && o_ready_c) begin
            r_data <= i_data;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_valid) w_state_nxt = START;
         START:   if (w_tick) w_state_nxt = DATA;
         DATA:    if (w_tick && (r_bit == 3'd7)) w_state_nxt = STOP;
         STOP:    if (w_tick) w_state_nxt = i_valid ? START : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_ready_c  = (r_state == IDLE) || ((r_state == STOP) && w_tick);
      w_cnt_nxt  = ((r_state == IDLE) || w_tick) ? '0 : r_cnt + CNT_W'(1);
      w_bit_nxt  = r_bit;
      if (r_state == START) begin
         w_bit_nxt = '0;
      end else if ((r_state == DATA) && w_tick) begin
         w_bit_nxt = r_bit + 3'd1;
      end
      w_busy_nxt = (w_state_nxt != IDLE);
      w_tx_nxt   = 1'b1;
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = r_data[w_bit_nxt];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign o_tx   = r_tx;
   assign o_busy = r_busy;

endmodule

// File: rtl/esfa_result_uart.sv
// Reports each completed ESFA run as a UART frame: header, status, error ID.
// Define ESFA_REPORT_CHECKSUM_EN to append an XOR checksum byte.
module esfa_result_uart
   import esfa_report_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       didRun,
   input  logic       wasSuccessful,
   input  logic [7:0] instructionOfError,
   output logic       tx,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   logic             r_didrun_q;
   logic             r_active;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_b1;
   logic [7:0]       r_b2;
   logic             r_frame_done;
   logic             r_overrun;

   logic             w_req;
   logic             w_start;
   logic             w_valid_c;
   logic             w_ready_c;
   logic             w_frame_end;
   logic [7:0]       w_next_byte;
   logic [7:0]       w_byte_c;
   logic             w_tx;
   logic             w_busy;

   assign w_req       = didRun & ~r_didrun_q;
   assign w_start     = w_req & ~r_active;
   assign w_valid_c   = w_start | (r_active & (r_idx != LAST_IDX));
   assign w_frame_end = r_active & w_ready_c & (r_idx == LAST_IDX);
   assign w_byte_c    = w_start ? HEADER_BYTE : w_next_byte;

`ifdef ESFA_REPORT_CHECKSUM_EN
   logic [7:0] w_chk;
   assign w_chk = HEADER_BYTE ^ r_b1 ^ r_b2;
`endif

   // Byte following the one currently on the line.
   always_comb begin
      w_next_byte = r_b1;
      case (r_idx)
         2'd0:    w_next_byte = r_b1;
         2'd1:    w_next_byte = r_b2;
`ifdef ESFA_REPORT_CHECKSUM_EN
         2'd2:    w_next_byte = w_chk;
`endif
         default: w_next_byte = r_b1;
      endcase
   end

   // r_active spans the whole frame, so an edge on the final stop cycle is still an overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_didrun_q   <= 1'b1;
         r_active     <= 1'b0;
         r_idx        <= '0;
         r_b1         <= '0;
         r_b2         <= '0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_didrun_q   <= didRun;
         r_frame_done <= w_frame_end;
         if (w_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
            r_b1     <= wasSuccessful ? STATUS_PASS : STATUS_FAIL;
            r_b2     <= wasSuccessful ? 8'h00 : instructionOfError;
         end else if (r_active && w_ready_c) begin
            if (r_idx == LAST_IDX) begin
               r_active <= 1'b0;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
         if (w_req && r_active) begin
            r_overrun <= 1'b1;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (w_valid_c),
      .i_data    (w_byte_c),
      .o_ready_c (w_ready_c),
      .o_tx      (w_tx),
      .o_busy    (w_busy)
   );

   assign tx         = w_tx;
   assign busy       = w_busy;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_esfa_result_uart.sv
// Randomised bench for esfa_result_uart: a UART receiver decodes tx and the
// decoded bytes are compared against frames built from the reporting rules.
module tb_esfa_result_uart;

   localparam int CPB = 4;
`ifdef ESFA_REPORT_CHECKSUM_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif
   localparam int FRAME_CYC = NB * 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       didRun = 1'b0;
   logic       wasSuccessful = 1'b0;
   logic [7:0] instructionOfError = 8'h00;
   logic       tx;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   int n_chk  = 0;
   int n_pass = 0;

   logic       rx_act = 1'b0;
   int         rx_off = 0;
   logic [7:0] rx_sh  = 8'h00;
   logic [7:0] rx_buf [0:255];
   int         rx_n     = 0;
   int         rx_err   = 0;
   int         busy_cyc = 0;
   int         fd_cnt   = 0;
   logic       exp_ovr  = 1'b0;

   esfa_result_uart #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .didRun             (didRun),
      .wasSuccessful      (wasSuccessful),
      .instructionOfError (instructionOfError),
      .tx                 (tx),
      .busy               (busy),
      .frame_done         (frame_done),
      .overrun            (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // Expected frame bytes packed little-endian: B0 in [7:0] .. B3 in [31:24].
   function automatic logic [31:0] model_frame(input logic succ, input logic [7:0] ioe);
      logic [7:0] b0, b1, b2;
      b0 = 8'hE5;
      b1 = succ ? 8'h01 : 8'h00;
      b2 = succ ? 8'h00 : ioe;
      return {b0 ^ b1 ^ b2, b2, b1, b0};
   endfunction

   // Receiver: start detected on first low sample, bits sampled mid-period.
   always @(negedge clk) begin
      if (reset) begin
         rx_act <= 1'b0;
      end else begin
         if (busy) busy_cyc <= busy_cyc + 1;
         if (frame_done) fd_cnt <= fd_cnt + 1;
         if (!rx_act) begin
            if (!tx) begin
               rx_act <= 1'b1;
               rx_off <= 1;
            end
         end else begin
            rx_off <= rx_off + 1;
            if (rx_off % CPB == CPB / 2) begin
               if (rx_off / CPB == 0) begin
                  if (tx) begin
                     rx_err <= rx_err + 1;
                     rx_act <= 1'b0;
                  end
               end else if (rx_off / CPB <= 8) begin
                  rx_sh <= {tx, rx_sh[7:1]};
               end else begin
                  if (!tx) rx_err <= rx_err + 1;
                  rx_buf[rx_n % 256] <= rx_sh;
                  rx_n   <= rx_n + 1;
                  rx_act <= 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_frame_done(input int f0, input string tag);
      int t = 0;
      while (fd_cnt == f0 && t < FRAME_CYC + 100) begin
         @(posedge clk);
         t++;
      end
      check(tag, 32'(fd_cnt != f0), 32'd1);
   endtask

   // mode 0: plain frame, 1: second didRun edge mid-frame, 2: inputs change after latch.
   task automatic run_frame(input logic succ, input logic [7:0] ioe, input int mode, input string tag);
      logic [31:0] fr;
      int rx0, b0, f0, e0;
      didRun = 1'b0;
      wasSuccessful = succ;
      instructionOfError = ioe;
      repeat (3) @(posedge clk);
      #1;
      fr  = model_frame(succ, ioe);
      rx0 = rx_n;
      b0  = busy_cyc;
      f0  = fd_cnt;
      e0  = rx_err;
      didRun = 1'b1;
      @(negedge clk);
      check({tag, "_pre_tx"}, 32'(tx), 32'd1);
      @(negedge clk);
      check({tag, "_start_tx"}, 32'(tx), 32'd0);
      check({tag, "_start_busy"}, 32'(busy), 32'd1);
      if (mode == 1) begin
         repeat (16) @(posedge clk);
         #1 didRun = 1'b0;
         @(posedge clk);
         #1 didRun = 1'b1;
         exp_ovr = 1'b1;
      end else if (mode == 2) begin
         repeat (30) @(posedge clk);
         #1;
         instructionOfError = 8'h55;
         wasSuccessful = ~succ;
      end
      wait_frame_done(f0, {tag, "_done"});
      repeat (3) @(negedge clk);
      check({tag, "_nbytes"}, 32'(rx_n - rx0), 32'(NB));
      for (int i = 0; i < NB; i++) begin
         check({tag, "_byte"}, 32'(rx_buf[(rx0 + i) % 256]), 32'(8'(fr >> (8 * i))));
      end
      check({tag, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(FRAME_CYC));
      check({tag, "_fd_pulses"}, 32'(fd_cnt - f0), 32'd1);
      check({tag, "_framing"}, 32'(rx_err - e0), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
      check({tag, "_idle_tx"}, 32'(tx), 32'd1);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      if (mode == 1) begin
         repeat (FRAME_CYC + 20) @(posedge clk);
         check({tag, "_no_second_frame"}, 32'(rx_n - rx0), 32'(NB));
         check({tag, "_no_second_fd"}, 32'(fd_cnt - f0), 32'd1);
         check({tag, "_overrun_sticky"}, 32'(overrun), 32'd1);
      end
   endtask

   initial begin
      int s_rx, s_busy, s_fd;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      run_frame(1'b1, 8'h00, 0, "pass");
      run_frame(1'b0, 8'h2A, 0, "fail2a");
      run_frame(1'b0, 8'h2A, 2, "latch");
      for (int i = 0; i < 6; i++) begin
         run_frame(1'($urandom_range(0, 1)), 8'($urandom), 0, "rand");
      end
      run_frame(1'b0, 8'h13, 1, "ovr");
      run_frame(1'b1, 8'h00, 0, "post_ovr");

      // didRun already high when reset releases must not report.
      didRun = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      exp_ovr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("hold_rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      s_rx   = rx_n;
      s_busy = busy_cyc;
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("hold_no_bytes", 32'(rx_n - s_rx), 32'd0);
      check("hold_no_busy", 32'(busy_cyc - s_busy), 32'd0);
      check("hold_tx", 32'(tx), 32'd1);
      run_frame(1'b0, 8'hA5, 0, "after_hold");

      // Reset at cycle 50 of a frame abandons it.
      didRun = 1'b0;
      wasSuccessful = 1'b0;
      instructionOfError = 8'h77;
      repeat (3) @(posedge clk);
      #1 didRun = 1'b1;
      s_fd = fd_cnt;
      repeat (50) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_tx_async", 32'(tx), 32'd1);
      check("abort_busy_async", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      repeat (FRAME_CYC) @(posedge clk);
      @(negedge clk);
      check("abort_no_fd", 32'(fd_cnt - s_fd), 32'd0);
      check("abort_idle_tx", 32'(tx), 32'd1);
      check("abort_idle_busy", 32'(busy), 32'd0);
      run_frame(1'b0, 8'h2A, 0, "after_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/esfa_result_uart.md
Name: esfa_result_uart

Overview:
- Downstream stage of the ESFA benchmark top.
- Consumes the run-completion status (didRun, wasSuccessful, instructionOfError) and, on each completed run, serialises a fixed result frame over a UART TX line (8N1, LSB first) to the board's USB-UART bridge.
- Gives host-side visibility of pass/fail and the failing instruction ID without a debugger.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- HEADER_BYTE, 8'hE5, first byte of every frame.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- didRun  in  1  level from benchmark top; a 0→1 transition requests a report
- wasSuccessful  in  1  pass(1)/fail(0), valid when didRun=1
- instructionOfError  in  8  failing instruction ID, valid when didRun=1
- tx  out  1  UART serial output, idle high
- busy  out  1  high from first start bit through last stop bit
- frame_done  out  1  one-cycle pulse after the last stop bit completes
- overrun  out  1  sticky; set when a request edge arrives while busy

Behaviour:
- Reset values: tx=1, busy=0, frame_done=0, overrun=0, bit counter=0, byte index=0, state=IDLE, didRun_q=1.
  - didRun_q resets to 1 so a didRun already high at reset release does not trigger a report.
- Edge detect: req = didRun & ~didRun_q; didRun_q registered every cycle.
- Frame bytes:
  - B0 = HEADER_BYTE.
  - B1 = {7'b0, wasSuccessful}.
  - B2 = wasSuccessful ? 8'h00 : instructionOfError.
  - All three latched in the cycle req is seen in IDLE; input changes afterwards do not affect the frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. On req, latch the frame, set byte index=0, go to START. tx goes low on the next rising edge, i.e. 1 cycle after the sampled edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = current byte[bit index] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte index < last, increment it and go directly to START (no idle gap);
    - otherwise go to IDLE and pulse frame_done for 1 cycle, concurrent with the first IDLE cycle.
- busy is registered and is 1 in START/DATA/STOP.
- Frame length: 30*CLKS_PER_BIT cycles (40*CLKS_PER_BIT with checksum).
- Overrun:
  - A req while busy is dropped and sets overrun; it is never queued.
  - overrun clears only on reset.
  - A req in the same cycle as the STOP→IDLE transition counts as busy and is dropped.
- Bit-period counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), wraps to 0 at each bit boundary.
- Reset mid-frame: line returns high asynchronously, frame is abandoned, no frame_done.

Optional Feature:
- Macro: ESFA_REPORT_CHECKSUM_EN.
- Defined: a fourth byte B3 = B0 ^ B1 ^ B2 is appended, so the frame is 4 bytes and last index = 3.
- Undefined: the frame is 3 bytes, last index = 2, and no checksum logic is present.

Decomposition:
- Package esfa_report_pkg holds:
  - FSM state enum (IDLE/START/DATA/STOP);
  - status codes STATUS_PASS=8'h01 and STATUS_FAIL=8'h00;
  - the FRAME_LEN constant, selected by the macro;
  - default HEADER_BYTE.
- One sub-module is natural: uart_tx_byte.
  - Serialises one byte with a start/ready handshake.
  - esfa_result_uart keeps edge detection, frame latching, byte sequencing, frame_done and overrun.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Pass run: wasSuccessful=1, didRun 0→1 → tx decodes E5 01 00, busy high exactly 120 cycles, single frame_done pulse, overrun=0.
- Fail run: wasSuccessful=0, instructionOfError=8'h2A, didRun 0→1 → frames E5 00 2A. With ESFA_REPORT_CHECKSUM_EN: E5 00 2A CF, busy 160 cycles.
- Second didRun edge 20 cycles into a frame → frame unaltered, no second frame, overrun=1 and remains 1 until reset.
- didRun held high through reset release → no frame, tx stays 1. A later 0→1 edge → one frame.
- Assert reset at cycle 50 of a frame → tx=1 and busy=0 asynchronously, no frame_done. After release, new edge → full correct frame.
- Input change after latch: instructionOfError changed 8'h2A→8'h55 mid-frame → B2 still 2A.
